// File: rtl/endian_swap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// endian_swap_ctrl_pkg
// Shared types and constants for the endian swap sequencer.
//   state_e       : controller FSM states
//   MODE_*        : cfg_mode encodings (3 is treated as pass)
//   DATA_W_LEGAL  : the only supported data width
// -----------------------------------------------------------------------------
package endian_swap_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_SWAP32 = 2'd1;
  localparam logic [1:0] MODE_SWAP16 = 2'd2;

  localparam int unsigned DATA_W_LEGAL = 32;

endpackage

// File: rtl/endian_swap_ctrl_if.sv
// -----------------------------------------------------------------------------
// endian_swap_ctrl_if
// Valid/ready word stream.
//   valid : producer has a word on data
//   data  : DATA_W-bit word
//   ready : consumer accepts data this cycle
// Modports: master drives valid/data, slave drives ready.
// -----------------------------------------------------------------------------
interface endian_swap_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/endian_swap_ctrl_lane.sv
// -----------------------------------------------------------------------------
// byte_swap_lane
// Combinational byte permutation selected by mode. The caller registers o_data.
//   i_mode : 0 pass, 1 swap32, 2 swap16 (or pass), 3 pass
//   i_data : input word
//   o_data : permuted word
// Build option: ENDIAN_SWAP_CTRL_SWAP16_EN enables the halfword swap for mode 2;
// without it mode 2 is pass and no swap16 mux exists.
// -----------------------------------------------------------------------------
module byte_swap_lane
  import endian_swap_ctrl_pkg::*;
(
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_SWAP32: o_data = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};
`ifdef ENDIAN_SWAP_CTRL_SWAP16_EN
      MODE_SWAP16: o_data = {i_data[23:16], i_data[31:24], i_data[7:0], i_data[15:8]};
`endif
      default:     o_data = i_data;
    endcase
  end

endmodule

// File: rtl/endian_swap_ctrl.sv
// -----------------------------------------------------------------------------
// endian_swap_ctrl
// Run sequencer for the byte-swap datapath: on an accepted run it latches a word
// count and swap mode, streams exactly that many words through a registered
// swap stage, and pulses o_done after the last output handshake.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   i_run      : start pulse, only sampled in idle
//   i_cfg_len  : word count (0 = empty run)
//   i_cfg_mode : 0 pass, 1 swap32, 2 swap16, 3 pass
//   s_in       : upstream stream (slave)
//   m_out      : downstream stream (master), registered
//   o_busy     : high outside idle
//   o_done     : one-cycle end-of-run pulse
// Build option: ENDIAN_SWAP_CTRL_SWAP16_EN (see byte_swap_lane).
// -----------------------------------------------------------------------------
module endian_swap_ctrl
  import endian_swap_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  input  logic [LEN_W-1:0]    i_cfg_len,
  input  logic [1:0]          i_cfg_mode,
  endian_swap_ctrl_if.slave   s_in,
  endian_swap_ctrl_if.master  m_out,
  output logic                o_busy,
  output logic                o_done
);

  if (DATA_W != DATA_W_LEGAL) begin : g_bad_data_w
    $error("endian_swap_ctrl: DATA_W must be 32");
  end

  state_e             r_state;
  state_e             w_state_d;
  logic [LEN_W-1:0]   r_len;
  logic [1:0]         r_mode;
  logic [LEN_W-1:0]   r_in_cnt;
  logic [LEN_W-1:0]   r_out_cnt;
  logic               r_out_valid;
  logic [31:0]        r_out_data;

  logic               w_in_ready;
  logic               w_load;
  logic               w_out_hs;
  logic               w_run_accept;
  logic [LEN_W-1:0]   w_in_cnt_inc;
  logic [LEN_W-1:0]   w_len_m1;
  logic [31:0]        w_swapped;

  assign w_run_accept = (r_state == StIdle) && i_run;
  assign w_load       = s_in.valid && w_in_ready;
  assign w_out_hs     = r_out_valid && m_out.ready;
  assign w_in_cnt_inc = r_in_cnt + LEN_W'(1);
  assign w_len_m1     = r_len - LEN_W'(1);

  byte_swap_lane u_lane (
    .i_mode (r_mode),
    .i_data (s_in.data),
    .o_data (w_swapped)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_run) w_state_d = (i_cfg_len == '0) ? StDone : StRun;
      StRun:   if (w_load && (w_in_cnt_inc == r_len)) w_state_d = StDrain;
      StDrain: if (w_out_hs && (r_out_cnt == w_len_m1)) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs. in_ready looks at out_ready so a full output stage can be
  // refilled in the same cycle it empties.
  always_comb begin
    o_busy     = (r_state != StIdle);
    o_done     = (r_state == StDone);
    w_in_ready = (r_state == StRun) && (r_in_cnt != r_len) && (!r_out_valid || m_out.ready);
    s_in.ready = w_in_ready;
    m_out.valid = r_out_valid;
    m_out.data  = r_out_data;
  end

  // Config, counters and the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_mode      <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_run_accept) begin
        r_len     <= i_cfg_len;
        r_mode    <= i_cfg_mode;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_load)   r_in_cnt  <= w_in_cnt_inc;
        if (w_out_hs) r_out_cnt <= r_out_cnt + LEN_W'(1);
      end
      // A load in the same cycle as an output handshake replaces the word.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_swapped;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_endian_swap_ctrl.sv
module tb_endian_swap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] cfg_len;
  logic [1:0]  cfg_mode;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] data_q[$];

  endian_swap_ctrl_if #(.DATA_W(32)) in_if ();
  endian_swap_ctrl_if #(.DATA_W(32)) out_if ();

  endian_swap_ctrl #(.DATA_W(32), .LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (run),
    .i_cfg_len  (cfg_len),
    .i_cfg_mode (cfg_mode),
    .s_in       (in_if),
    .m_out      (out_if),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: output byte i is drawn from an input byte index chosen by mode.
  function automatic logic [31:0] model(input logic [31:0] w, input logic [1:0] m);
    logic [7:0]  b [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    r = w;
    if (m == 2'd1) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = b[3-i];
    end
`ifdef ENDIAN_SWAP_CTRL_SWAP16_EN
    else if (m == 2'd2) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i ^ 1];
    end
`endif
    return r;
  endfunction

  function automatic logic [31:0] next_word();
    if (data_q.size() > 0) return data_q.pop_front();
    return $urandom;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_if.ready),  0);
    check({tag, "_out_valid"}, 32'(out_if.valid), 0);
    check({tag, "_out_data"},  out_if.data,       0);
    check({tag, "_busy"},      32'(busy),         0);
    check({tag, "_done"},      32'(done),         0);
  endtask

  // One run: strict = out_ready/in_valid held high with 1-cycle latency checks,
  // rnd = random valid/ready, rerun_at = cycle to pulse a conflicting run,
  // abort_at = output count at which reset is asserted mid-cycle.
  task automatic run_stream(input int len, input logic [1:0] mode, input bit strict,
                            input bit rnd, input int rerun_at, input int abort_at);
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    int          accepted = 0;
    int          outs = 0;
    int          cyc;
    bit          done_due;
    bit          prev_stall = 1'b0;
    bit          in_hs;
    bit          out_hs;
    logic [31:0] prev_data = '0;
    logic [31:0] cur_word;

    cur_word = next_word();
    @(negedge clk);
    run      = 1'b1;
    cfg_len  = 16'(len);
    cfg_mode = mode;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    @(negedge clk);
    run      = 1'b0;
    cfg_len  = 16'($urandom);
    cfg_mode = 2'($urandom);
    #1;
    check("busy_after_run", 32'(busy), 1);
    done_due = (len == 0);
    for (cyc = 0; cyc < 300; cyc++) begin
      in_if.valid  = rnd ? 1'($urandom) : 1'b1;
      in_if.data   = cur_word;
      out_if.ready = rnd ? 1'($urandom) : 1'b1;
      if (cyc == rerun_at) begin
        run      = 1'b1;
        cfg_len  = 16'd2;
        cfg_mode = mode ^ 2'b01;
      end else begin
        run = 1'b0;
      end
      #1;
      check("done", 32'(done), 32'(done_due));
      if (done_due) begin
        check("busy_in_done", 32'(busy), 1);
        check("in_ready_in_done", 32'(in_if.ready), 0);
        break;
      end
      in_hs  = in_if.valid && in_if.ready;
      out_hs = out_if.valid && out_if.ready;
      if (accepted == len) check("in_ready_closed", 32'(in_if.ready), 0);
      if (prev_stall) check("stall_hold", out_if.data, prev_data);
      if (strict && cyc == 0) check("first_accept", 32'(in_hs), 1);
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(outs), 32'(accepted));
        end else begin
          check("out_data", out_if.data, exp_q[0]);
          if (strict) check("latency", 32'(cyc - cyc_q[0]), 1);
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
        outs++;
      end
      if (in_hs && accepted < len) begin
        exp_q.push_back(model(cur_word, mode));
        cyc_q.push_back(cyc);
        accepted++;
        cur_word = next_word();
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_data  = out_if.data;
      done_due   = out_hs && (outs == len);
      if (abort_at > 0 && outs == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        run = 1'b0;
        in_if.valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (cyc >= 300) check("timeout", 32'(cyc), 0);
    run = 1'b0;
    @(negedge clk);
    in_if.valid = 1'b0;
    #1;
    check("busy_after_done", 32'(busy), 0);
    check("done_single", 32'(done), 0);
    check("out_count", 32'(outs), 32'(len));
    check("in_count", 32'(accepted), 32'(len));
  endtask

  initial begin
    rst_n        = 1'b0;
    run          = 1'b0;
    cfg_len      = '0;
    cfg_mode     = '0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate swap32 with the fixed vectors
    data_q = '{32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'h01020304};
    run_stream(4, 2'd1, 1'b1, 1'b0, -1, 0);

    // Mode 2 (swap16 only when the option is built in)
    data_q = '{32'hA1B2C3D4};
    run_stream(3, 2'd2, 1'b0, 1'b0, -1, 0);

    // Random backpressure and gaps
    run_stream(5, 2'($urandom), 1'b0, 1'b1, -1, 0);

    // Empty run
    run_stream(0, 2'd1, 1'b0, 1'b0, -1, 0);

    // run while busy must be ignored
    run_stream(4, 2'd1, 1'b0, 1'b1, 2, 0);

    // Reset after two outputs of six
    run_stream(6, 2'd1, 1'b0, 1'b0, -1, 2);
    @(negedge clk);
    @(negedge clk);
    #1 check_reset_outputs("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_abort_done", 32'(done), 0);
      check("post_abort_busy", 32'(busy), 0);
    end
    run_stream(1, 2'd2, 1'b0, 1'b0, -1, 0);

    // Random runs, all modes
    for (int k = 0; k < 6; k++) begin
      run_stream(int'($urandom_range(1, 8)), 2'($urandom), 1'b0, 1'b1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
